dcache_assoc: RTL and testbench
===============================

Name: dcache_assoc

Overview:
- Parametrised N-way set-associative, physically tagged, write-through / no-write-allocate L1 data cache.
- Sits between the memory-stage load/store path, after translation, and the memory bus.
- Replaces the single-way tag/data array with configurable ways, sets and line length.
- Adds a line-refill miss FSM, a write-through bus path and a whole-cache flush.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 64, sets per way; power of two, >=2.
- LINE_WORDS, 4, 32-bit words per line; power of two, >=2.

Ports:
- clk_core  in  1  core clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  [28:2]  physical word address.
- req_wdata  in  32  store data.
- req_mask  in  4  store byte enables.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load data; 0 for stores.
- bus_req  out  1  bus command valid; held until bus_ack.
- bus_ack  in  1  command accepted this cycle.
- bus_write  out  1  1 = write-through store, 0 = line read.
- bus_addr  out  [28:2]  command word address.
- bus_wdata  out  32  store data.
- bus_mask  out  4  store byte enables.
- bus_rvalid  in  1  refill beat valid.
- bus_rdata  in  32  refill beat data.
- flush_req  in  1  invalidate entire cache.
- flush_done  out  1  one-cycle pulse when flush completes.
- perf_hits  out  32  see Optional Feature.
- perf_misses  out  32  see Optional Feature.

Behaviour:
- Address split: OFF_W = log2(LINE_WORDS), IDX_W = log2(SETS). Word offset = req_addr[2+OFF_W-1:2]. Index = next IDX_W bits. Tag = remaining bits up to bit 28.
- Valid bits live in flops. Tag and data arrays may be synchronous RAM, read in the accept cycle.
- Reset: all valid bits 0, victim pointers 0, FSM to IDLE. All outputs 0 except req_ready, which is 1 from the first cycle after reset.
- Reset mid-refill or mid-write: the operation aborts with no response. The bus is reset alongside.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL, WRITE, FLUSH.
- IDLE:
  - req_ready = !flush_req.
  - flush_req has priority over a simultaneous req_valid; flush_req goes to FLUSH.
  - An accepted request is registered and goes to LOOKUP.
- LOOKUP: compare all ways; at most one way hits.
  - Read hit: resp_valid with the word, same cycle, i.e. latency 1. Return to IDLE.
  - Read miss: go to REFILL_REQ.
  - Write hit: merge bytes per req_mask into the hit way, then go to WRITE.
  - Write miss: no allocate; go to WRITE.
- REFILL_REQ:
  - Drive bus_req=1, bus_write=0, bus_addr = line base (offset 0).
  - Victim: lowest-numbered invalid way, else the per-set round-robin pointer.
  - On bus_ack, go to REFILL.
- REFILL:
  - Accept exactly LINE_WORDS bus_rvalid beats, word 0 first, written into the victim way. Gaps between beats are allowed.
  - Capture the requested word as it passes.
  - Cycle after the final beat: set valid, write tag, advance the set's pointer (mod WAYS), pulse resp_valid with the captured word, go to IDLE.
  - bus_rvalid outside REFILL is ignored.
- WRITE:
  - Drive bus_req=1, bus_write=1, request address, data and mask. Hold them stable until bus_ack.
  - Cycle after bus_ack: resp_valid with resp_rdata=0, go to IDLE.
- FLUSH:
  - Clear valid bits for one set per cycle, set 0 to SETS-1, over SETS cycles.
  - Pulse flush_done on the cycle after the last set, go to IDLE.
  - flush_req is ignored outside IDLE.
- bus_req is never asserted in IDLE, LOOKUP or FLUSH.
- At most one outstanding request at a time.

Optional Feature:
- Macro: DCACHE_PERF_EN.
- Defined:
  - perf_hits increments on each LOOKUP hit, read or write.
  - perf_misses increments on each LOOKUP miss.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, reset to 0 and are unaffected by flush.
- Undefined: no counter logic; both ports tied to 0.

Test Plan:
- Load 0x0000100 after reset -> bus_req, bus_write=0, bus_addr=0x0000100. Feed beats 0xA0..0xA3 -> resp_rdata=0xA0 the cycle after the 4th beat. Repeat load -> resp_valid 1 cycle after accept, no bus_req.
- Load 0x0000102 with beats stalled 2 cycles apart -> resp_rdata=third beat. flush_req held during refill ignored until IDLE.
- Store 0x0000101 data 0xDEADBEEF mask 0b0011 to a cached line holding 0x11223344 -> later load returns 0x1122BEEF. Bus write carries mask 0b0011. Hold bus_ack low 3 cycles -> bus outputs stable, no response until ack.
- Store to an uncached line -> bus write issued; following load to it misses and refills.
- WAYS=2: fill 3 lines mapping to set 0 -> third refill evicts way 0; reload first line misses; next eviction targets way 1.
- flush_req together with req_valid in IDLE -> req_ready=0, flush_done after SETS+1 cycles, all subsequent loads miss. With DCACHE_PERF_EN, counters match the hit/miss totals.

Source files
------------

// File: rtl/dcache_assoc.sv
// N-way set-associative write-through, no-write-allocate L1 data cache.
// Optional hit/miss counters are built when DCACHE_PERF_EN is defined.
module dcache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [28:2] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        bus_write,
  output logic [28:2] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        flush_req,
  output logic        flush_done,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 27 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL_REQ, REFILL, WRITE, FLUSH
  } state_t;

  state_t state_q, state_d;

  logic              r_write;
  logic [28:2]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_mask;
  logic [WAY_W-1:0]  victim_q;
  logic [OFF_W-1:0]  beat_q;
  logic [31:0]       cap_q;
  logic              fin_q;
  logic [IDX_W-1:0]  flush_idx;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
  logic [31:0]       data_mem[WAYS][SETS][LINE_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  vic;
  logic [WAY_W-1:0]  rr_next;
  logic [31:0]       hit_word;

  assign idx = r_addr[2+OFF_W +: IDX_W];
  assign off = r_addr[2 +: OFF_W];
  assign tag = r_addr[28 -: TAG_W];

  // Lowest invalid way wins the victim slot, else the round-robin pointer.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic     = rr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) vic = WAY_W'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_mem[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_word = data_mem[hit_way][idx][off];
  assign rr_next  = (rr_q[idx] == WAY_W'(WAYS - 1)) ?
                    '0 : rr_q[idx] + 1'b1;

  always_ff @(posedge clk_core) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req)      state_d = FLUSH;
        else if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (r_write)  state_d = WRITE;
        else if (hit) state_d = IDLE;
        else          state_d = REFILL_REQ;
      end
      REFILL_REQ: if (bus_ack) state_d = REFILL;
      REFILL:     if (fin_q)   state_d = IDLE;
      WRITE:      if (fin_q)   state_d = IDLE;
      FLUSH:      if (fin_q)   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    bus_req    = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_mask   = '0;
    flush_done = 1'b0;
    unique case (state_q)
      IDLE: req_ready = reset_n & ~flush_req;
      LOOKUP: begin
        if (!r_write && hit) begin
          resp_valid = 1'b1;
          resp_rdata = hit_word;
        end
      end
      REFILL_REQ: begin
        bus_req  = 1'b1;
        bus_addr = {r_addr[28:2+OFF_W], {OFF_W{1'b0}}};
      end
      REFILL: begin
        if (fin_q) begin
          resp_valid = 1'b1;
          resp_rdata = cap_q;
        end
      end
      WRITE: begin
        if (fin_q) begin
          resp_valid = 1'b1;
        end else begin
          bus_req   = 1'b1;
          bus_write = 1'b1;
          bus_addr  = r_addr;
          bus_wdata = r_wdata;
          bus_mask  = r_mask;
        end
      end
      FLUSH:   flush_done = fin_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      victim_q  <= '0;
      beat_q    <= '0;
      cap_q     <= '0;
      fin_q     <= 1'b0;
      flush_idx <= '0;
      valid_q   <= '{default: '0};
      rr_q      <= '{default: '0};
    end else begin
      unique case (state_q)
        IDLE: begin
          fin_q     <= 1'b0;
          beat_q    <= '0;
          flush_idx <= '0;
          if (!flush_req && req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mask  <= req_mask;
          end
        end
        LOOKUP: victim_q <= vic;
        REFILL: begin
          if (!fin_q && bus_rvalid) begin
            if (beat_q == off) cap_q <= bus_rdata;
            beat_q <= beat_q + 1'b1;
            if (beat_q == OFF_W'(LINE_WORDS - 1)) fin_q <= 1'b1;
          end
          if (fin_q) begin
            valid_q[idx][victim_q] <= 1'b1;
            rr_q[idx]              <= rr_next;
          end
        end
        WRITE: if (!fin_q && bus_ack) fin_q <= 1'b1;
        FLUSH: begin
          if (!fin_q) begin
            valid_q[flush_idx] <= '0;
            flush_idx          <= flush_idx + 1'b1;
            if (flush_idx == IDX_W'(SETS - 1)) fin_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk_core) begin
    if (reset_n) begin
      if (state_q == LOOKUP && r_write && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (r_mask[b])
            data_mem[hit_way][idx][off][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
      if (state_q == REFILL && !fin_q && bus_rvalid)
        data_mem[victim_q][idx][beat_q] <= bus_rdata;
      if (state_q == REFILL && fin_q)
        tag_mem[victim_q][idx] <= tag;
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hits_q, miss_q;

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      hits_q <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hits_q <= hits_q + 1'b1;
      else     miss_q <= miss_q + 1'b1;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = miss_q;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: table of load/store transactions
// with a scripted bus, plus flush and reset corner sequences.
module tb_dcache_assoc;

  localparam int SETS = 64;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [26:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        bus_req;
  logic        bus_ack;
  logic        bus_write;
  logic [26:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_mask;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        flush_req;
  logic        flush_done;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  int tests = 0;
  int fails = 0;
  int n_hit = 0;
  int n_miss = 0;

  dcache_assoc #(.WAYS(2), .SETS(SETS), .LINE_WORDS(4)) dut (
    .clk_core   (clk_core),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_mask   (req_mask),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_mask   (bus_mask),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .perf_hits  (perf_hits),
    .perf_misses(perf_misses)
  );

  always #5 clk_core = ~clk_core;

  typedef struct packed {
    logic        wr;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        miss;
    logic [31:0] fill;
    logic [31:0] rd;
    logic [3:0]  gap;
    logic [3:0]  ack_dly;
    logic        fh;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string s;
    s = $sformatf("v%0d", id);
    @(negedge clk_core);
    chk({s, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_mask  = v.mask;
    @(negedge clk_core);
    req_valid = 1'b0;
    if (v.fh) flush_req = 1'b1;
    if (v.miss) n_miss++;
    else        n_hit++;
    if (!v.wr && !v.miss) begin
      chk({s, " hit valid"}, 32'(resp_valid), 32'd1);
      chk({s, " hit data"}, resp_rdata, v.rd);
      chk({s, " hit no bus"}, 32'(bus_req), 32'd0);
    end else if (!v.wr) begin
      chk({s, " miss no resp"}, 32'(resp_valid), 32'd0);
      @(negedge clk_core);
      chk({s, " rf bus_req"}, 32'(bus_req), 32'd1);
      chk({s, " rf bus_write"}, 32'(bus_write), 32'd0);
      chk({s, " rf bus_addr"}, 32'(bus_addr),
          32'({v.addr[26:2], 2'b00}));
      bus_ack = 1'b1;
      @(negedge clk_core);
      bus_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
        repeat (v.gap) begin
          @(negedge clk_core);
          chk({s, " gap no resp"}, 32'(resp_valid), 32'd0);
        end
        bus_rvalid = 1'b1;
        bus_rdata  = v.fill + 32'(i);
        @(negedge clk_core);
        bus_rvalid = 1'b0;
      end
      flush_req = 1'b0;
      chk({s, " rf resp valid"}, 32'(resp_valid), 32'd1);
      chk({s, " rf resp data"}, resp_rdata, v.rd);
      chk({s, " rf no flush"}, 32'(flush_done), 32'd0);
    end else begin
      chk({s, " wr no resp"}, 32'(resp_valid), 32'd0);
      @(negedge clk_core);
      chk({s, " wr bus_req"}, 32'(bus_req), 32'd1);
      chk({s, " wr bus_write"}, 32'(bus_write), 32'd1);
      chk({s, " wr bus_addr"}, 32'(bus_addr), 32'(v.addr));
      chk({s, " wr bus_wdata"}, bus_wdata, v.wdata);
      chk({s, " wr bus_mask"}, 32'(bus_mask), 32'(v.mask));
      repeat (v.ack_dly) begin
        @(negedge clk_core);
        chk({s, " hold bus_req"}, 32'(bus_req), 32'd1);
        chk({s, " hold addr"}, 32'(bus_addr), 32'(v.addr));
        chk({s, " hold wdata"}, bus_wdata, v.wdata);
        chk({s, " hold mask"}, 32'(bus_mask), 32'(v.mask));
        chk({s, " hold no resp"}, 32'(resp_valid), 32'd0);
      end
      bus_ack = 1'b1;
      @(negedge clk_core);
      bus_ack = 1'b0;
      chk({s, " wr resp valid"}, 32'(resp_valid), 32'd1);
      chk({s, " wr resp data"}, resp_rdata, 32'd0);
      chk({s, " wr bus idle"}, 32'(bus_req), 32'd0);
    end
  endtask

  initial begin
    int k;
    vec_t v;
    // wr addr wdata mask miss fill rd gap ack_dly fh
    tbl[0]  = '{1'b0, 27'h100, 32'h0, 4'h0, 1'b1, 32'hA0, 32'hA0, 4'd0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 27'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'hA0, 4'd0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 27'h103, 32'h0, 4'h0, 1'b0, 32'h0, 32'hA3, 4'd0, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 27'h106, 32'h0, 4'h0, 1'b1, 32'h11223343, 32'h11223345, 4'd2, 4'd0, 1'b1};
    tbl[4]  = '{1'b0, 27'h106, 32'h0, 4'h0, 1'b0, 32'h0, 32'h11223345, 4'd0, 4'd0, 1'b0};
    tbl[5]  = '{1'b1, 27'h105, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0, 32'h0, 4'd0, 4'd3, 1'b0};
    tbl[6]  = '{1'b0, 27'h105, 32'h0, 4'h0, 1'b0, 32'h0, 32'h1122BEEF, 4'd0, 4'd0, 1'b0};
    tbl[7]  = '{1'b0, 27'h104, 32'h0, 4'h0, 1'b0, 32'h0, 32'h11223343, 4'd0, 4'd0, 1'b0};
    tbl[8]  = '{1'b1, 27'h300, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, 27'h300, 32'h0, 4'h0, 1'b1, 32'hC0, 32'hC0, 4'd0, 4'd0, 1'b0};
    tbl[10] = '{1'b0, 27'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'hA0, 4'd0, 4'd0, 1'b0};
    tbl[11] = '{1'b0, 27'h502, 32'h0, 4'h0, 1'b1, 32'hD0, 32'hD2, 4'd0, 4'd0, 1'b0};
    tbl[12] = '{1'b0, 27'h301, 32'h0, 4'h0, 1'b0, 32'h0, 32'hC1, 4'd0, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 27'h100, 32'h0, 4'h0, 1'b1, 32'hE0, 32'hE0, 4'd0, 4'd0, 1'b0};
    tbl[14] = '{1'b0, 27'h500, 32'h0, 4'h0, 1'b0, 32'h0, 32'hD0, 4'd0, 4'd0, 1'b0};
    tbl[15] = '{1'b0, 27'h300, 32'h0, 4'h0, 1'b1, 32'hF0, 32'hF0, 4'd0, 4'd0, 1'b0};
    tbl[16] = '{1'b0, 27'h101, 32'h0, 4'h0, 1'b0, 32'h0, 32'hE1, 4'd0, 4'd0, 1'b0};

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_mask   = '0;
    bus_ack    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    flush_req  = 1'b0;
    repeat (3) @(negedge clk_core);
    reset_n = 1'b1;
    @(negedge clk_core);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst flush_done", 32'(flush_done), 32'd0);
    chk("rst perf_hits", perf_hits, 32'd0);
    chk("rst perf_misses", perf_misses, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

    // Flush beats a simultaneous request and empties the cache.
    @(negedge clk_core);
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 27'h500;
    #1;
    chk("flush req_ready", 32'(req_ready), 32'd0);
    @(negedge clk_core);
    flush_req = 1'b0;
    req_valid = 1'b0;
    k = 1;
    while (!flush_done && k < 300) begin
      @(negedge clk_core);
      chk("flush no resp", 32'(resp_valid), 32'd0);
      k++;
    end
    chk("flush cycles", 32'(k), 32'(SETS + 1));
    v = '{1'b0, 27'h502, 32'h0, 4'h0, 1'b1, 32'h70, 32'h72, 4'd0, 4'd0, 1'b0};
    run_vec(v, 100);
    v = '{1'b0, 27'h500, 32'h0, 4'h0, 1'b0, 32'h0, 32'h70, 4'd0, 4'd0, 1'b0};
    run_vec(v, 101);
    v = '{1'b0, 27'h104, 32'h0, 4'h0, 1'b1, 32'h80, 32'h80, 4'd0, 4'd0, 1'b0};
    run_vec(v, 102);

`ifdef DCACHE_PERF_EN
    chk("perf_hits", perf_hits, 32'(n_hit));
    chk("perf_misses", perf_misses, 32'(n_miss));
`else
    chk("perf_hits", perf_hits, 32'd0);
    chk("perf_misses", perf_misses, 32'd0);
`endif

    // Reset during a refill abandons it without a response.
    @(negedge clk_core);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 27'h900;
    @(negedge clk_core);
    req_valid = 1'b0;
    @(negedge clk_core);
    chk("mid bus_req", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk_core);
    chk("mid rst bus_req", 32'(bus_req), 32'd0);
    chk("mid rst resp", 32'(resp_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_core);
    chk("mid rst ready", 32'(req_ready), 32'd1);
    v = '{1'b0, 27'h100, 32'h0, 4'h0, 1'b1, 32'h90, 32'h90, 4'd0, 4'd0, 1'b0};
    run_vec(v, 103);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
